uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one single-byte UART transmitter among N_REQ independent byte-stream requesters.
- Round-robin arbitration at packet granularity: a granted requester keeps the transmitter until its byte flagged last has fully left the line.
- Sequences the transmitter through a start pulse and its busy handshake, inserts an optional inter-packet guard gap, and aborts requesters that stall mid-packet.
- Sits between the protocol/message generators and the UART transmitter in the debug/upgrade link.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clock cycles inserted after each packet before re-arbitration; 0 = no gap.
- STALL_MAX, 1024, cycles a granted requester may leave req_valid low in FETCH before abort; 0 disables abort.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  byte is the final byte of its packet.
- req_ready  out  N_REQ  byte accepted this cycle when valid & ready.
- grant  out  N_REQ  one-hot owner of the transmitter; all zero when idle.
- uart_start  out  1  one-cycle start pulse to the transmitter.
- uart_data  out  8  byte to transmit; held stable from start until the next byte is accepted.
- uart_busy  in  1  transmitter busy; rises the cycle after uart_start.
- abort  out  1  one-cycle pulse when a stalled packet is aborted.
- abort_id  out  3  index of the aborted requester; valid while abort=1, otherwise holds its last value.

Behaviour:
- Reset (async, reset_n=0): state IDLE, grant=0, req_ready=0, uart_start=0, uart_data=0, abort=0, abort_id=0, round-robin pointer=N_REQ-1, counters cleared. Reset mid-packet drops the packet silently; the UART is reset separately.
- FSM states: IDLE, FETCH, START, WAIT_HI, WAIT_LO, GAP.
- IDLE: if any req_valid, choose the first set bit searching upward from pointer+1 (wrapping). Register grant and pointer=winner, go to FETCH. Otherwise stay.
- FETCH:
  - req_ready[g]=1 (combinational from state and grant); all other ready bits 0.
  - On req_valid[g]: latch req_data into uart_data, latch req_last, go to START.
  - If not valid: increment stall counter. When the counter reaches STALL_MAX-1 (and STALL_MAX≠0): pulse abort, set abort_id=g, clear grant, go to IDLE.
  - Stall counter clears on every accepted byte.
- START: uart_start=1 for exactly one cycle, go to WAIT_HI.
- WAIT_HI: wait for uart_busy=1, then go to WAIT_LO. There is no timeout; the transmitter guarantees busy the next cycle.
- WAIT_LO: on uart_busy=0:
  - If last is latched: go to GAP, or to IDLE with grant cleared when GAP_CYCLES=0.
  - Otherwise go to FETCH.
- GAP: grant=0, count GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - Byte accepted at edge k; uart_start is high in cycle k+1.
  - Earliest next-byte acceptance is one cycle after busy falls.
  - Packet-to-packet turnaround with GAP_CYCLES=0 is 2 cycles after busy falls (IDLE, then FETCH).
- Requesters changing req_valid/req_data while not granted are ignored. Requests arriving while another packet is active wait; there is no preemption.
- A single-byte packet (first byte has last=1) is legal.
- uart_start is never asserted while uart_busy=1.

Test Plan:
- Single requester 0 sends bytes 0x55, 0xA3(last); UART model busy 20 cycles -> two uart_start pulses with uart_data 0x55 then 0xA3; grant=0001 throughout; grant=0000 after the second busy falls.
- Requesters 1 and 3 both valid in IDLE, pointer=0 -> requester 1 granted first; after its last byte, requester 3 is granted; then requester 1 again if it is still requesting (round-robin fairness).
- Requester 2 raises last=1 on its first byte 0x7E -> exactly one start pulse; req_ready[2] high for exactly the accepting cycle.
- STALL_MAX=16: requester 0 sends 0x01 (not last), then holds valid low -> abort pulses 16 FETCH cycles later with abort_id=0; grant clears; a pending requester 2 is granted next.
- GAP_CYCLES=5 with two back-to-back packets -> 5 cycles of grant=0 between the first packet's busy fall and the second packet's IDLE decision.
- reset_n asserted during WAIT_LO -> all outputs return to reset values immediately (async); after release, pending requesters are re-arbitrated starting from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one single-byte UART transmitter among N_REQ byte-stream
//   requesters. Arbitration is round-robin at packet granularity: the
//   granted requester owns the transmitter until its last byte has left
//   the line. Each byte is handed over with a one-cycle start pulse and
//   the transmitter's busy handshake. An optional guard gap follows each
//   packet, and a requester that stalls mid-packet is aborted.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   req_valid   per-requester byte available
//   req_data    per-requester byte, requester i on [8i+7:8i]
//   req_last    byte is the final byte of its packet
//   req_ready   byte accepted this cycle when valid & ready
//   grant       one-hot transmitter owner, zero when idle
//   uart_start  one-cycle start pulse to the transmitter
//   uart_data   byte to transmit, held until the next byte is accepted
//   uart_busy   transmitter busy, rises the cycle after uart_start
//   abort       one-cycle pulse when a stalled packet is aborted
//   abort_id    index of the aborted requester, holds its last value
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int STALL_MAX  = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_busy,
  output logic               abort,
  output logic [2:0]         abort_id
);

  localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LIM = SW'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);
  localparam logic [GW-1:0] GAP_LIM   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [2:0]        r_ptr, w_ptr_nxt;        // last winner == current owner
  logic [7:0]        r_data, w_data_nxt;
  logic              r_last, w_last_nxt;
  logic [SW-1:0]     r_stall, w_stall_nxt;
  logic [GW-1:0]     r_gap, w_gap_nxt;
  logic              r_abort, w_abort_nxt;
  logic [2:0]        r_abort_id, w_abort_id_nxt;

  logic [2:0]        w_win_idx;
  int                w_dist, w_best;
  logic              w_sel_valid, w_sel_last;
  logic [7:0]        w_sel_data;

  // Round-robin pick: smallest upward distance from r_ptr+1, wrapping.
  always_comb begin
    w_win_idx = r_ptr;
    w_best    = N_REQ;
    w_dist    = 0;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = j - int'(r_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (req_valid[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_win_idx = 3'(j);
      end
    end
  end

  // Inputs of the current owner.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_ptr == 3'(j)) begin
        w_sel_valid = req_valid[j];
        w_sel_last  = req_last[j];
        w_sel_data  = req_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_ptr_nxt      = r_ptr;
    w_data_nxt     = r_data;
    w_last_nxt     = r_last;
    w_stall_nxt    = r_stall;
    w_gap_nxt      = r_gap;
    w_abort_nxt    = 1'b0;
    w_abort_id_nxt = r_abort_id;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_grant_nxt = ONE_HOT0 << w_win_idx;
          w_ptr_nxt   = w_win_idx;
          w_stall_nxt = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_sel_valid) begin
          w_data_nxt  = w_sel_data;
          w_last_nxt  = w_sel_last;
          w_stall_nxt = '0;
          w_state_nxt = S_START;
        end else if ((STALL_MAX != 0) && (r_stall == STALL_LIM)) begin
          w_abort_nxt    = 1'b1;
          w_abort_id_nxt = r_ptr;
          w_grant_nxt    = '0;
          w_stall_nxt    = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_stall_nxt = r_stall + 1'b1;
        end
      end
      S_START:   w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (uart_busy) w_state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!uart_busy) begin
          if (r_last) begin
            w_grant_nxt = '0;
            w_gap_nxt   = '0;
            w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LIM) w_state_nxt = S_IDLE;
        else                  w_gap_nxt   = r_gap + 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ptr      <= 3'(N_REQ - 1);
      r_data     <= 8'h00;
      r_last     <= 1'b0;
      r_stall    <= '0;
      r_gap      <= '0;
      r_abort    <= 1'b0;
      r_abort_id <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_data     <= w_data_nxt;
      r_last     <= w_last_nxt;
      r_stall    <= w_stall_nxt;
      r_gap      <= w_gap_nxt;
      r_abort    <= w_abort_nxt;
      r_abort_id <= w_abort_id_nxt;
    end
  end

  assign req_ready  = (r_state == S_FETCH) ? r_grant : '0;
  assign grant      = r_grant;
  assign uart_start = (r_state == S_START);
  assign uart_data  = r_data;
  assign abort      = r_abort;
  assign abort_id   = r_abort_id;

endmodule
